// File: rtl/ttl_pkg.sv
// Shared gate-function codes and evaluation helpers for the TTL gate bank models.
package ttl_pkg;

   localparam logic [2:0] TTL_NAND = 3'd0;
   localparam logic [2:0] TTL_NOR  = 3'd1;
   localparam logic [2:0] TTL_AND  = 3'd2;
   localparam logic [2:0] TTL_OR   = 3'd3;
   localparam logic [2:0] TTL_XOR  = 3'd4;
   localparam logic [2:0] TTL_XNOR = 3'd5;

   function automatic logic ttl_gate_eval(input logic [2:0] func, input logic a, input logic b);
      logic r;
      case (func)
         TTL_NAND: r = ~(a & b);
         TTL_NOR:  r = ~(a | b);
         TTL_AND:  r = a & b;
         TTL_OR:   r = a | b;
         TTL_XOR:  r = a ^ b;
         TTL_XNOR: r = ~(a ^ b);
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

   // Quiescent output level: the gate's response with both inputs low.
   function automatic logic ttl_idle(input logic [2:0] func);
      return ttl_gate_eval(func, 1'b0, 1'b0);
   endfunction

endpackage

// File: rtl/ttl_glitch_filter.sv
// Single-channel glitch filter: q follows d only after d has differed from q
// for FILTER consecutive ce-qualified clocks; any reversal restarts the count.
module ttl_glitch_filter #(
   parameter int   FILTER = 1,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic d,
   output logic q
);

   localparam int CW = $clog2(FILTER + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          q_q, q_d;

   always_comb begin
      cnt_d = cnt_q;
      q_d   = q_q;
      if (ce) begin
         if (d == q_q) begin
            cnt_d = '0;
         end else if (cnt_q == CW'(FILTER - 1)) begin
            q_d   = d;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         q_q   <= INIT;
      end else begin
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/ttl_gate_bank.sv
// Bank of CHANNELS identical 2-input TTL gates with a DELAY-stage clocked
// propagation line, optional glitch filter and optional open-collector output.
module ttl_gate_bank
   import ttl_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int FUNC           = 0,
   parameter int DELAY          = 1,
   parameter int FILTER         = 0,
   parameter int OPEN_COLLECTOR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ce,
   input  logic [CHANNELS-1:0] a,
   input  logic [CHANNELS-1:0] b,
   output logic [CHANNELS-1:0] y,
   output logic [CHANNELS-1:0] y_oe
);

   localparam logic [2:0] FSEL = 3'(FUNC);
   localparam logic       IDLE = ttl_idle(FSEL);
   localparam int         DW   = (DELAY < 1) ? 1 : DELAY;

   if (FUNC < 0 || FUNC > 5) begin : g_bad_func
      $error("ttl_gate_bank: FUNC must be in 0..5");
   end
   if (DELAY < 1) begin : g_bad_delay
      $error("ttl_gate_bank: DELAY must be >= 1");
   end

   logic [CHANNELS-1:0]         f;
   logic [CHANNELS-1:0]         y_val;
   logic [DW-1:0][CHANNELS-1:0] dly_q, dly_d;

   // All channels shift together; ce=0 freezes the whole line.
   always_comb begin
      dly_d = dly_q;
      if (ce) begin
         dly_d[0] = f;
         for (int j = 1; j < DW; j++) begin
            dly_d[j] = dly_q[j-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dly_q <= {(DW*CHANNELS){IDLE}};
      end else begin
         dly_q <= dly_d;
      end
   end

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      assign f[ch] = ttl_gate_eval(FSEL, a[ch], b[ch]);

      if (FILTER == 0) begin : g_nofilt
         assign y_val[ch] = dly_q[DW-1][ch];
      end else begin : g_filt
         ttl_glitch_filter #(
            .FILTER (FILTER),
            .INIT   (IDLE)
         ) u_filt (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (ce),
            .d     (dly_q[DW-1][ch]),
            .q     (y_val[ch])
         );
      end
   end

   // Open-collector: pin is driven only when pulling low; a released pin reads 1.
   if (OPEN_COLLECTOR != 0) begin : g_oc
      assign y    = y_val;
      assign y_oe = ~y_val;
   end else begin : g_pp
      assign y    = y_val;
      assign y_oe = '1;
   end

endmodule

// File: tb/tb_ttl_gate_bank.sv
// Directed bench: six parameterisations of ttl_gate_bank sharing one clock and reset.
module tb_ttl_gate_bank;

   logic clk = 1'b0;
   logic rst_n;
   logic ce, ce3;
   logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4, a5, b5;
   logic [3:0] y0, oe0, y1, oe1, y2, oe2, y3, oe3, y4, oe4, y5, oe5;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // d0: NAND, DELAY=1 (defaults)
   ttl_gate_bank u_d0 (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a0), .b(b0), .y(y0), .y_oe(oe0));
   // d1: OR, DELAY=3
   ttl_gate_bank #(.FUNC(3), .DELAY(3)) u_d1
      (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a1), .b(b1), .y(y1), .y_oe(oe1));
   // d2: OR, DELAY=1, FILTER=3
   ttl_gate_bank #(.FUNC(3), .DELAY(1), .FILTER(3)) u_d2
      (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a2), .b(b2), .y(y2), .y_oe(oe2));
   // d3: OR, DELAY=2, own ce
   ttl_gate_bank #(.FUNC(3), .DELAY(2)) u_d3
      (.clk(clk), .rst_n(rst_n), .ce(ce3), .a(a3), .b(b3), .y(y3), .y_oe(oe3));
   // d4: NAND, open collector
   ttl_gate_bank #(.FUNC(0), .OPEN_COLLECTOR(1)) u_d4
      (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a4), .b(b4), .y(y4), .y_oe(oe4));
   // d5: OR, DELAY=1, FILTER=2
   ttl_gate_bank #(.FUNC(3), .DELAY(1), .FILTER(2)) u_d5
      (.clk(clk), .rst_n(rst_n), .ce(ce), .a(a5), .b(b5), .y(y5), .y_oe(oe5));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b1; ce3 = 1'b1;
      a0 = 4'hF; b0 = 4'hF;
      a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
      a4 = '0; b4 = '0; a5 = '0; b5 = '0;

      // Reset state: every output at FUNC(0,0)
      tick();
      check("rst_d0_y",   y0,  4'hF);
      check("rst_d0_oe",  oe0, 4'hF);
      check("rst_d1_y",   y1,  4'h0);
      check("rst_d2_y",   y2,  4'h0);
      check("rst_d4_y",   y4,  4'hF);
      check("rst_d4_oe",  oe4, 4'h0);
      check("rst_d5_y",   y5,  4'h0);

      // 1: NAND of all-ones visible one edge after release
      rst_n = 1'b1;
      tick();
      check("t1_nand_y", y0, 4'h0);

      // 2: OR with DELAY=3, a[2] rises at edge k
      a1 = 4'b0100;
      tick();
      check("t2_k",   y1, 4'b0000);
      tick();
      check("t2_k1",  y1, 4'b0000);
      tick();
      check("t2_k2",  y1, 4'b0100);
      tick();
      check("t2_hold", y1, 4'b0100);

      // 3a: 2-clock pulse is swallowed by FILTER=3
      a2 = 4'b0001;
      tick(); tick();
      a2 = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_short", y2, 4'b0000);
      end
      // 3b: 3-clock pulse reaches y on the 4th edge from its start
      a2 = 4'b0001;
      tick(); tick(); tick();
      a2 = 4'b0000;
      check("t3_k2", y2, 4'b0000);
      tick();
      check("t3_k3", y2, 4'b0001);
      tick(); tick();
      check("t3_k5", y2, 4'b0001);
      tick();
      check("t3_k6", y2, 4'b0000);

      // 4: ce stalls a DELAY=2 transition
      a3 = 4'b0001;
      tick();
      check("t4_first", y3, 4'b0000);
      ce3 = 1'b0;
      tick();
      check("t4_frz1", y3, 4'b0000);
      tick();
      check("t4_frz2", y3, 4'b0000);
      ce3 = 1'b1;
      tick();
      check("t4_second", y3, 4'b0001);

      // 5: open-collector NAND, only ch1 pulled low
      a4 = 4'b0010; b4 = 4'b0010;
      tick();
      check("t5_y",  y4,  4'b1101);
      check("t5_oe", oe4, 4'b0010);

      // 6: reset mid-count on FILTER=2, input held high through it
      a5 = 4'b0001;
      tick(); tick();
      check("t6_pre", y5, 4'b0000);
      rst_n = 1'b0;
      tick();
      check("t6_rst", y5, 4'b0000);
      rst_n = 1'b1;
      tick();
      check("t6_r0", y5, 4'b0000);
      tick();
      check("t6_r1", y5, 4'b0000);
      tick();
      check("t6_r2", y5, 4'b0001);
      check("t6_d0_after", y0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
